lcd_receiver: RTL and testbench

Responder end of the 4-bit HD44780-style LCD bus driven by the LCD text/init sender and `lcd_transfer`. It samples `LCD_D`/`LCD_E` inside the FPGA clock domain and tracks the 8-bit boot sequence and the switch to 4-bit mode. It reassembles nibble pairs into bytes and decodes them into character writes, with DDRAM address tracking, and into controller state. It serves as an on-chip LCD emulator for mirroring text to another display or to a bench monitor, and as a protocol and timing checker.

---
 rtl/lcd_receiver.sv | 155 +++++++++++++++
 tb/tb_lcd_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_receiver.sv
// rtl/lcd_receiver.sv - 4-bit HD44780-style LCD bus responder, decoder and protocol/timing checker
module lcd_receiver #(
    parameter int T_EXEC  = 1850,
    parameter int T_CLEAR = 76000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] LCD_D,
    input  logic       LCD_E,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic [6:0] char_addr,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    output logic       four_bit_mode,
    output logic       two_line,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       timing_err,
    output logic       proto_err
);

    localparam int T_MAX = (T_CLEAR > T_EXEC) ? T_CLEAR : T_EXEC;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {BOOT8, HI, LO} state_t;

    state_t        state;
    logic          e_q;
    logic          hi_rs;
    logic [3:0]    hi_nib;
    logic [6:0]    addr;
    logic [CW-1:0] cnt;
    logic          strobe;
    logic [7:0]    lo_byte;

    assign strobe  = e_q & ~LCD_E;
    assign busy    = (cnt != '0);
    assign lo_byte = {hi_nib, LCD_D[3:0]};

    // DDRAM has two 40-column lines at 0x00-0x27 and 0x40-0x67
    function automatic logic [6:0] step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= BOOT8;
            e_q           <= 1'b0;
            hi_rs         <= 1'b0;
            hi_nib        <= 4'h0;
            addr          <= 7'h00;
            cnt           <= '0;
            char_valid    <= 1'b0;
            char_data     <= 8'h00;
            char_addr     <= 7'h00;
            cmd_valid     <= 1'b0;
            cmd_data      <= 8'h00;
            four_bit_mode <= 1'b0;
            two_line      <= 1'b0;
            display_on    <= 1'b0;
            cursor_on     <= 1'b0;
            blink_on      <= 1'b0;
            entry_inc     <= 1'b1;
            timing_err    <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            e_q        <= LCD_E;
            char_valid <= 1'b0;
            cmd_valid  <= 1'b0;
            if (busy) cnt <= cnt - 1'b1;

            if (strobe) begin
                case (state)
                    BOOT8: begin
                        if (busy) timing_err <= 1'b1;
                        cnt <= CW'(T_EXEC);
                        if (!LCD_D[4] && LCD_D[3:0] == 4'h3) begin
                            cmd_valid <= 1'b1;
                            cmd_data  <= 8'h30;
                        end else if (!LCD_D[4] && LCD_D[3:0] == 4'h2) begin
                            cmd_valid     <= 1'b1;
                            cmd_data      <= 8'h20;
                            four_bit_mode <= 1'b1;
                            state         <= HI;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                    HI: begin
                        if (busy) timing_err <= 1'b1;
                        hi_rs  <= LCD_D[4];
                        hi_nib <= LCD_D[3:0];
                        state  <= LO;
                    end
                    LO: begin
                        state <= HI;
                        cnt   <= (!hi_rs && lo_byte inside {8'h01, 8'h02, 8'h03}) ?
                                 CW'(T_CLEAR) : CW'(T_EXEC);
                        // the RS latched with the high nibble decides the byte type
                        if (LCD_D[4] != hi_rs) proto_err <= 1'b1;
                        if (hi_rs) begin
                            char_valid <= 1'b1;
                            char_data  <= lo_byte;
                            char_addr  <= addr;
                            addr       <= step(addr, entry_inc);
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_data  <= lo_byte;
                            casez (lo_byte)
                                8'b1???_????: begin
                                    if (lo_byte[5:0] >= 6'h28) begin
                                        proto_err <= 1'b1;
                                        addr      <= 7'h00;
                                    end else begin
                                        addr <= lo_byte[6:0];
                                    end
                                end
                                8'b01??_????: ;
                                8'b001?_????: begin
                                    two_line <= lo_byte[3];
                                    if (lo_byte[4]) begin
                                        four_bit_mode <= 1'b0;
                                        state         <= BOOT8;
                                    end
                                end
                                8'b0001_????: if (!lo_byte[3]) addr <= step(addr, lo_byte[2]);
                                8'b0000_1???: {display_on, cursor_on, blink_on} <= lo_byte[2:0];
                                8'b0000_01??: entry_inc <= lo_byte[1];
                                8'b0000_001?: addr <= 7'h00;
                                8'b0000_0001: begin
                                    addr      <= 7'h00;
                                    entry_inc <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= BOOT8;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_receiver.sv
// tb/tb_lcd_receiver.sv - scoreboard bench for lcd_receiver with a byte-level LCD reference model
module tb_lcd_receiver;

    localparam int TE = 20;
    localparam int TC = 150;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [4:0] LCD_D;
    logic       LCD_E;
    logic       char_valid, cmd_valid;
    logic [7:0] char_data, cmd_data;
    logic [6:0] char_addr;
    logic       four_bit_mode, two_line, display_on, cursor_on, blink_on;
    logic       entry_inc, busy, timing_err, proto_err;

    lcd_receiver #(.T_EXEC(TE), .T_CLEAR(TC)) dut (
        .CLK(CLK), .RST_N(RST_N), .LCD_D(LCD_D), .LCD_E(LCD_E),
        .char_valid(char_valid), .char_data(char_data), .char_addr(char_addr),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .four_bit_mode(four_bit_mode), .two_line(two_line), .display_on(display_on),
        .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
        .busy(busy), .timing_err(timing_err), .proto_err(proto_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         is_char;
        logic [7:0] data;
        logic [6:0] addr;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // reference model: phase 0 = 8-bit boot, 1 = awaiting high nibble, 2 = awaiting low nibble
    int   m_phase, m_addr, last_p, last_t;
    bit   m_hi_rs, m_four, m_two, m_disp, m_cur, m_blink, m_inc, m_terr, m_perr;
    logic [3:0] m_hi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mstep(input int a, input bit up);
        int idx;
        idx = (a >= 64) ? 40 + a - 64 : a;
        idx = up ? (idx + 1) % 80 : (idx + 79) % 80;
        return (idx >= 40) ? 64 + idx - 40 : idx;
    endfunction

    task automatic push(input bit is_char, input logic [7:0] d, input int a);
        exp_t e;
        e.is_char = is_char;
        e.data    = d;
        e.addr    = 7'(a);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_phase = 0; m_addr = 0; last_p = -1000; last_t = 0;
        m_hi_rs = 0; m_hi = 0; m_four = 0; m_two = 0; m_disp = 0; m_cur = 0;
        m_blink = 0; m_inc = 1; m_terr = 0; m_perr = 0;
    endtask

    task automatic model_byte(input bit rs, input logic [7:0] b, input int q);
        int a;
        last_p = q;
        last_t = (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? TC : TE;
        if (rs) begin
            push(1, b, m_addr);
            m_addr = mstep(m_addr, m_inc);
            return;
        end
        push(0, b, 0);
        if (b >= 8'h80) begin
            a = int'(b) - 128;
            if ((a % 64) >= 40) begin m_perr = 1; m_addr = 0; end
            else m_addr = a;
        end else if (b >= 8'h40) begin
        end else if (b >= 8'h20) begin
            m_two = b[3];
            if (b[4]) begin m_four = 0; m_phase = 0; end
        end else if (b >= 8'h10) begin
            if (!b[3]) m_addr = mstep(m_addr, b[2]);
        end else if (b >= 8'h08) begin
            m_disp = b[2]; m_cur = b[1]; m_blink = b[0];
        end else if (b >= 8'h04) begin
            m_inc = b[1];
        end else if (b >= 8'h02) begin
            m_addr = 0;
        end else if (b == 8'h01) begin
            m_addr = 0; m_inc = 1;
        end
    endtask

    task automatic model_strobe(input bit rs, input logic [3:0] nib, input int q);
        if (m_phase != 2 && (q - last_p) <= last_t) m_terr = 1;
        case (m_phase)
            0: begin
                last_p = q; last_t = TE;
                if (!rs && nib == 4'h3) push(0, 8'h30, 0);
                else if (!rs && nib == 4'h2) begin push(0, 8'h20, 0); m_four = 1; m_phase = 1; end
                else m_perr = 1;
            end
            1: begin m_hi_rs = rs; m_hi = nib; m_phase = 2; end
            default: begin
                if (rs != m_hi_rs) m_perr = 1;
                m_phase = 1;
                model_byte(m_hi_rs, {m_hi, nib}, q);
            end
        endcase
    endtask

    task automatic check_flags(input string name);
        bit mbusy;
        mbusy = (cyc - last_p) < last_t;
        chk(name, {four_bit_mode, two_line, display_on, cursor_on, blink_on, entry_inc,
                   busy, timing_err, proto_err},
            {m_four, m_two, m_disp, m_cur, m_blink, m_inc, mbusy, m_terr, m_perr});
    endtask

    task automatic check_reset();
        chk("reset_data", {char_valid, cmd_valid, char_data, cmd_data, char_addr}, 32'h0);
        chk("reset_flags", {four_bit_mode, two_line, display_on, cursor_on, blink_on, entry_inc,
                            busy, timing_err, proto_err}, 32'b000001000);
    endtask

    // gap > 0 places the strobe exactly gap cycles after the last completed byte (if still possible)
    task automatic strobe(input bit rs, input logic [3:0] nib, input int gap);
        int target;
        target = (gap > 0) ? last_p + gap : last_p + last_t + 1;
        while (cyc + 2 < target) @(negedge CLK);
        LCD_D = {rs, nib};
        LCD_E = 1'b1;
        @(negedge CLK);
        LCD_E = 1'b0;
        model_strobe(rs, nib, cyc + 1);
        @(negedge CLK);
        check_flags("flags");
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b, input int gap);
        strobe(rs, b[7:4], gap);
        strobe(rs, b[3:0], 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check_reset();
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic lcd_init();
        strobe(0, 4'h3, 0); strobe(0, 4'h3, 0); strobe(0, 4'h3, 0); strobe(0, 4'h2, 0);
        send_byte(0, 8'h2C, 0); send_byte(0, 8'h08, 0); send_byte(0, 8'h01, 0);
        send_byte(0, 8'h06, 0); send_byte(0, 8'h0C, 0);
    endtask

    always @(negedge CLK) begin
        if (char_valid || cmd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'h0, char_valid, cmd_valid}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", {30'h0, char_valid, cmd_valid}, mon_e.is_char ? 32'h2 : 32'h1);
                if (mon_e.is_char) begin
                    chk("char_data", {24'h0, char_data}, {24'h0, mon_e.data});
                    chk("char_addr", {25'h0, char_addr}, {25'h0, mon_e.addr});
                end else begin
                    chk("cmd_data", {24'h0, cmd_data}, {24'h0, mon_e.data});
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit         rs;
        int         gap;
        model_reset();
        LCD_D = 5'h00; LCD_E = 1'b1; RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset();
        // E falls in the release cycle: must be ignored
        RST_N = 1'b1; LCD_E = 1'b0; LCD_D = 5'h03;
        repeat (3) @(negedge CLK);
        check_flags("post_reset");

        lcd_init();
        send_byte(1, "A", 0); send_byte(1, "B", 0);
        send_byte(0, 8'hC0, 0); send_byte(1, "C", 0);
        send_byte(0, 8'hA7, 0); send_byte(1, "x", 0); send_byte(1, "y", 0);
        send_byte(0, 8'h04, 0); send_byte(0, 8'h80, 0);
        send_byte(1, "z", 0); send_byte(1, "w", 0);
        send_byte(0, 8'h90, 0); send_byte(1, "p", 0);
        send_byte(0, 8'hA8, 0); send_byte(1, "q", 0);

        do_reset();
        lcd_init();
        send_byte(0, 8'h01, 0);
        send_byte(0, 8'h06, TC + 1);
        send_byte(0, 8'h0C, TE);

        do_reset();
        lcd_init();
        strobe(0, 4'h4, 0); strobe(1, 4'h1, 0);
        send_byte(0, 8'h01, 0);
        send_byte(1, "k", 50);

        do_reset();
        strobe(1, 4'h3, 0);
        strobe(0, 4'h3, 0); strobe(0, 4'h2, 0);
        strobe(0, 4'h2, 0);
        do_reset();
        strobe(0, 4'h2, 0);

        do_reset();
        lcd_init();
        for (int i = 0; i < 200; i++) begin
            rs = 0;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin rs = 1; b = 8'($urandom_range(8'h20, 8'h7E)); end
                5: b = 8'h80 | 8'($urandom_range(0, 127));
                6: b = 8'h10 | 8'($urandom_range(0, 15));
                7: b = 8'h08 | 8'($urandom_range(0, 7));
                8: b = 8'h06 | 8'($urandom_range(0, 1) << 1) & 8'h07;
                default: b = 8'($urandom_range(1, 3)) | (($urandom_range(0, 1) == 1) ? 8'h28 : 8'h00);
            endcase
            gap = ($urandom_range(0, 15) == 0) ? $urandom_range(1, TE) : 0;
            strobe(rs, b[7:4], gap);
            if ($urandom_range(0, 15) == 0) strobe(!rs, b[3:0], 0);
            else strobe(rs, b[3:0], 0);
        end

        repeat (5) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
